// File: rtl/bp_be_dcache_pkg.sv
// Shared dcache types: uncached store entry, size encodings and the LCE request
// format / CCE id mapping used by the uncached store buffer.
package bp_be_dcache_pkg;

   localparam int paddr_width_p         = 40;
   localparam int dword_width_p         = 64;
   localparam int lce_id_width_p        = 4;
   localparam int cce_id_width_p        = 4;
   localparam int block_offset_width_lp = 6;

   typedef enum logic [1:0] {
      e_uc_size_1B = 2'd0,
      e_uc_size_2B = 2'd1,
      e_uc_size_4B = 2'd2,
      e_uc_size_8B = 2'd3
   } bp_be_dcache_uc_size_e;

   typedef enum logic [2:0] {
      e_mem_msg_size_1  = 3'd0,
      e_mem_msg_size_2  = 3'd1,
      e_mem_msg_size_4  = 3'd2,
      e_mem_msg_size_8  = 3'd3,
      e_mem_msg_size_16 = 3'd4,
      e_mem_msg_size_32 = 3'd5,
      e_mem_msg_size_64 = 3'd6
   } bp_mem_msg_size_e;

   typedef enum logic [1:0] {
      e_lce_req_type_rd    = 2'd0,
      e_lce_req_type_wr    = 2'd1,
      e_lce_req_type_uc_rd = 2'd2,
      e_lce_req_type_uc_wr = 2'd3
   } bp_lce_cce_req_type_e;

   typedef struct packed {
      logic [paddr_width_p-1:0] addr;
      logic [dword_width_p-1:0] data;
      logic [1:0]               size;
   } bp_be_dcache_uc_store_entry_s;

   typedef struct packed {
      logic [cce_id_width_p-1:0] dst_id;
      logic [lce_id_width_p-1:0] src_id;
      bp_lce_cce_req_type_e      msg_type;
      logic                      non_exclusive;
      logic [2:0]                lru_way_id;
      bp_mem_msg_size_e          size;
      logic [paddr_width_p-1:0]  addr;
      logic [dword_width_p-1:0]  data;
   } bp_lce_cce_req_s;

   localparam int lce_cce_req_width_lp = $bits(bp_lce_cce_req_s);

   // CCEs are interleaved on cache-block granularity.
   function automatic logic [cce_id_width_p-1:0] bp_me_addr_to_cce_id(
      input logic [paddr_width_p-1:0] paddr
   );
      return cce_id_width_p'(paddr >> block_offset_width_lp);
   endfunction

endpackage

// File: rtl/bp_be_dcache_uc_credit_counter.sv
// Up/down counter of outstanding uncached writes; holds at zero on an
// unmatched return and exposes a registered full flag.
module bp_be_dcache_uc_credit_counter #(
   parameter int credits_p = 8,
   localparam int width_lp = $clog2(credits_p + 1)
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                inc_i,
   input  logic                dec_i,
   output logic [width_lp-1:0] count_o,
   output logic                full_o,
   output logic                zero_o
);

   logic [width_lp-1:0] count_q, count_d;
   logic                full_q, full_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && !dec_i) begin
         count_d = count_q + 1'b1;
      end else if (dec_i && !inc_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
      full_d = (count_d == width_lp'(credits_p));
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
         full_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         full_q  <= full_d;
      end
   end

   assign count_o = count_q;
   assign full_o  = full_q;
   assign zero_o  = (count_q == '0);

`ifndef SYNTHESIS
   underflow_a: assert property (@(posedge clk_i) disable iff (reset_i)
      !(dec_i && !inc_i && (count_q == '0)));
`endif

endmodule

// File: rtl/bp_be_dcache_uc_store_buffer.sv
// Uncached store buffer feeding uc_wr requests onto the LCE request channel.
// Optional same-cycle bypass into an idle buffer: BP_DCACHE_UC_STORE_BYPASS_EN.
module bp_be_dcache_uc_store_buffer
   import bp_be_dcache_pkg::*;
#(
   parameter int els_p     = 4,
   parameter int credits_p = 8
) (
   input  logic                            clk_i,
   input  logic                            reset_i,
   input  logic [lce_id_width_p-1:0]       lce_id_i,
   input  logic                            uc_store_v_i,
   input  logic [paddr_width_p-1:0]        uc_store_addr_i,
   input  logic [dword_width_p-1:0]        uc_store_data_i,
   input  logic [1:0]                      uc_store_size_i,
   output logic                            uc_store_ready_o,
   output logic [lce_cce_req_width_lp-1:0] lce_req_o,
   output logic                            lce_req_v_o,
   input  logic                            lce_req_ready_i,
   input  logic                            credit_return_i,
   output logic                            credits_full_o,
   output logic                            empty_o
);

   localparam int idx_width_lp    = $clog2(els_p);
   localparam int credit_width_lp = $clog2(credits_p + 1);

   bp_be_dcache_uc_store_entry_s mem_q [els_p];
   bp_be_dcache_uc_store_entry_s mem_d [els_p];
   logic [idx_width_lp:0]        wptr_q, wptr_d, rptr_q, rptr_d;

   logic full, empty, accept, wr_en, deq_v, bypass;
   logic credits_full, credits_zero;
   logic [credit_width_lp-1:0] credit_count;

   bp_be_dcache_uc_store_entry_s in_entry, head_entry, send_entry;
   bp_lce_cce_req_s              req;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[idx_width_lp-1:0] == rptr_q[idx_width_lp-1:0])
                && (wptr_q[idx_width_lp] != rptr_q[idx_width_lp]);

   assign uc_store_ready_o = ~full;
   assign accept           = uc_store_v_i & ~full;
   assign deq_v            = ~empty & lce_req_ready_i & ~credits_full;

`ifdef BP_DCACHE_UC_STORE_BYPASS_EN
   assign bypass = accept & empty & ~credits_full & lce_req_ready_i;
`else
   assign bypass = 1'b0;
`endif

   assign wr_en       = accept & ~bypass;
   assign lce_req_v_o = deq_v | bypass;

   always_comb begin
      in_entry      = '0;
      in_entry.addr = uc_store_addr_i;
      in_entry.data = uc_store_data_i;
      in_entry.size = uc_store_size_i;
   end

   assign head_entry = mem_q[rptr_q[idx_width_lp-1:0]];

   // Power-of-two depth: plain increment wraps the index and toggles the wrap bit.
   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (wr_en) begin
         mem_d[wptr_q[idx_width_lp-1:0]] = in_entry;
         wptr_d = wptr_q + 1'b1;
      end
      if (deq_v) begin
         rptr_d = rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         mem_q  <= '{default: '0};
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_comb begin
      send_entry = bypass ? in_entry : head_entry;
      req          = '0;
      req.dst_id   = bp_me_addr_to_cce_id(send_entry.addr);
      req.src_id   = lce_id_i;
      req.msg_type = e_lce_req_type_uc_wr;
      req.size     = bp_mem_msg_size_e'({1'b0, send_entry.size});
      req.addr     = send_entry.addr;
      req.data     = send_entry.data;
   end

   assign lce_req_o = req;

   bp_be_dcache_uc_credit_counter #(
      .credits_p (credits_p)
   ) credit_counter (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (lce_req_v_o),
      .dec_i   (credit_return_i),
      .count_o (credit_count),
      .full_o  (credits_full),
      .zero_o  (credits_zero)
   );

   assign credits_full_o = credits_full;
   assign empty_o        = empty & credits_zero;

`ifndef SYNTHESIS
   no_write_full_a: assert property (@(posedge clk_i) disable iff (reset_i)
      !(wr_en && full));
   dword_align_a: assert property (@(posedge clk_i) disable iff (reset_i)
      !(uc_store_v_i && (uc_store_size_i == e_uc_size_8B) && (uc_store_addr_i[2:0] != 3'b000)));
   credit_bound_a: assert property (@(posedge clk_i) disable iff (reset_i)
      credit_count <= credit_width_lp'(credits_p));
`endif

endmodule

// File: tb/tb_bp_be_dcache_uc_store_buffer.sv
// Scoreboard bench for the uncached store buffer (els_p=4, credits_p=8).
module tb_bp_be_dcache_uc_store_buffer;
   import bp_be_dcache_pkg::*;

`ifdef BP_DCACHE_UC_STORE_BYPASS_EN
   localparam bit byp_lp = 1'b1;
`else
   localparam bit byp_lp = 1'b0;
`endif
   localparam logic [lce_id_width_p-1:0] lce_id_lp = 4'h5;

   logic clk = 1'b0;
   logic rst, v, lrdy, cret;
   logic [paddr_width_p-1:0] addr;
   logic [dword_width_p-1:0] data;
   logic [1:0] size;
   logic rdy_o, req_v, cfull, empty;
   logic [lce_cce_req_width_lp-1:0] req;

   bp_be_dcache_uc_store_entry_s exp_q[$];
   int checks = 0, errors = 0, sent = 0, outstanding = 0;

   always #5 clk = ~clk;

   bp_be_dcache_uc_store_buffer #(
      .els_p     (4),
      .credits_p (8)
   ) dut (
      .clk_i            (clk),
      .reset_i          (rst),
      .lce_id_i         (lce_id_lp),
      .uc_store_v_i     (v),
      .uc_store_addr_i  (addr),
      .uc_store_data_i  (data),
      .uc_store_size_i  (size),
      .uc_store_ready_o (rdy_o),
      .lce_req_o        (req),
      .lce_req_v_o      (req_v),
      .lce_req_ready_i  (lrdy),
      .credit_return_i  (cret),
      .credits_full_o   (cfull),
      .empty_o          (empty)
   );

   // scoreboard: every send must match the oldest accepted store
   always @(negedge clk) begin
      bp_be_dcache_uc_store_entry_s e;
      bp_lce_cce_req_s got, want;
      if (rst === 1'b0 && req_v === 1'b1) begin
         checks++;
         sent++;
         outstanding++;
         got = bp_lce_cce_req_s'(req);
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_send: got addr=%h data=%h, required no request", got.addr, got.data);
         end else begin
            e = exp_q.pop_front();
            want          = '0;
            want.dst_id   = e.addr[9:6];
            want.src_id   = lce_id_lp;
            want.msg_type = e_lce_req_type_uc_wr;
            want.size     = bp_mem_msg_size_e'({1'b0, e.size});
            want.addr     = e.addr;
            want.data     = e.data;
            if (got !== want) begin
               errors++;
               $display("FAIL req_fields: got %h required %h", got, want);
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rst === 1'b0 && cret === 1'b1) outstanding--;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_store(input logic [paddr_width_p-1:0] a,
                             input logic [dword_width_p-1:0] d,
                             input logic [1:0] s);
      bp_be_dcache_uc_store_entry_s e;
      v = 1'b1; addr = a; data = d; size = s;
      for (int k = 0; k < 500; k++) begin
         if (rdy_o === 1'b1) begin
            e.addr = a; e.data = d; e.size = s;
            exp_q.push_back(e);
            tick(1);
            v = 1'b0;
            return;
         end
         tick(1);
      end
      v = 1'b0;
      checks++;
      errors++;
      $display("FAIL push_timeout: got ready=%b for 500 cycles, required 1", rdy_o);
   endtask

   task automatic drain(input string name);
      lrdy = 1'b1;
      for (int k = 0; k < 500; k++) begin
         if (exp_q.size() == 0 && outstanding == 0) break;
         cret = (outstanding > 0);
         tick(1);
      end
      cret = 1'b0;
      checks++;
      if (exp_q.size() != 0 || outstanding != 0) begin
         errors++;
         $display("FAIL %s_drain: got pending=%0d outstanding=%0d, required 0 and 0", name, exp_q.size(), outstanding);
      end
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL %s_empty_o: got %b required 1", name, empty);
      end
   endtask

   task automatic test_reset();
      lrdy = 1'b1;
      #1;
      checks++; if (rdy_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", rdy_o); end
      checks++; if (req_v !== 1'b0) begin errors++; $display("FAIL reset_req_v: got %b required 0", req_v); end
      checks++; if (cfull !== 1'b0) begin errors++; $display("FAIL reset_credits_full: got %b required 0", cfull); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b required 1", empty); end
      tick(2);
   endtask

   task automatic test_single();
      lrdy = 1'b1;
      push_store(40'h00_8000_0010, 64'h0000_0000_DEAD_BEEF, 2'd2);
      checks++;
      if (req_v !== (byp_lp ? 1'b0 : 1'b1)) begin
         errors++; $display("FAIL single_latency: got req_v=%b required %b", req_v, !byp_lp);
      end
      tick(1);
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_sent: got pending=%0d required 0", exp_q.size()); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty_busy: got %b required 0", empty); end
      cret = 1'b1;
      tick(1);
      cret = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_done: got %b required 1", empty); end
   endtask

   task automatic test_fill();
      int s0;
      lrdy = 1'b0;
      for (int i = 0; i < 4; i++) push_store(40'h00_1000_0000 + 40'(i * 64), 64'hA0 + 64'(i), 2'd3);
      checks++; if (rdy_o !== 1'b0) begin errors++; $display("FAIL fill_full: got ready=%b required 0", rdy_o); end
      checks++; if (req_v !== 1'b0) begin errors++; $display("FAIL fill_hold: got req_v=%b required 0", req_v); end
      s0 = sent;
      lrdy = 1'b1;
      tick(1);
      checks++; if (rdy_o !== 1'b1) begin errors++; $display("FAIL fill_reready: got ready=%b required 1", rdy_o); end
      tick(3);
      checks++; if (sent - s0 != 4) begin errors++; $display("FAIL fill_burst: got %0d sends in 4 cycles required 4", sent - s0); end
      drain("fill");
   endtask

   task automatic test_credit_stall();
      int s0;
      lrdy = 1'b1;
      s0 = sent;
      for (int i = 0; i < 10; i++) push_store(40'h00_2000_0000 + 40'(i * 8), 64'hC000 + 64'(i), 2'(i % 4));
      tick(5);
      checks++; if (sent - s0 != 8) begin errors++; $display("FAIL stall_sent: got %0d required 8", sent - s0); end
      checks++; if (cfull !== 1'b1) begin errors++; $display("FAIL stall_full: got %b required 1", cfull); end
      checks++; if (req_v !== 1'b0) begin errors++; $display("FAIL stall_req_v: got %b required 0", req_v); end
      checks++; if (exp_q.size() != 2) begin errors++; $display("FAIL stall_held: got %0d required 2", exp_q.size()); end
      cret = 1'b1;
      tick(1);
      cret = 1'b0;
      tick(4);
      checks++; if (sent - s0 != 9) begin errors++; $display("FAIL stall_one_more: got %0d required 9", sent - s0); end
      drain("stall");
   endtask

   task automatic test_same_cycle();
      int s0, s1;
      lrdy = 1'b1;
      s0 = sent;
      for (int i = 0; i < 3; i++) push_store(40'h00_3000_0000 + 40'(i * 64), 64'hD0 + 64'(i), 2'd1);
      tick(2);
      lrdy = 1'b0;
      push_store(40'h00_3000_1000, 64'hD3, 2'd0);
      lrdy = 1'b1;
      cret = 1'b1;
      tick(1);
      cret = 1'b0;
      checks++; if (sent - s0 != 4) begin errors++; $display("FAIL same_send: got %0d required 4", sent - s0); end
      s1 = sent;
      for (int i = 0; i < 6; i++) push_store(40'h00_3100_0000 + 40'(i * 64), 64'hE0 + 64'(i), 2'd2);
      tick(6);
      checks++; if (sent - s1 != 5) begin errors++; $display("FAIL same_count3: got %0d more sends required 5", sent - s1); end
      checks++; if (cfull !== 1'b1) begin errors++; $display("FAIL same_full: got %b required 1", cfull); end
      drain("same_credit");

      lrdy = 1'b0;
      push_store(40'h00_3200_0000, 64'hF0, 2'd2);
      push_store(40'h00_3200_0040, 64'hF1, 2'd2);
      lrdy = 1'b1;
      push_store(40'h00_3200_0080, 64'hF2, 2'd2);
      lrdy = 1'b0;
      push_store(40'h00_3200_00C0, 64'hF3, 2'd2);
      checks++; if (rdy_o !== 1'b1) begin errors++; $display("FAIL occ_three: got ready=%b required 1", rdy_o); end
      push_store(40'h00_3200_0100, 64'hF4, 2'd2);
      checks++; if (rdy_o !== 1'b0) begin errors++; $display("FAIL occ_four: got ready=%b required 0", rdy_o); end
      drain("occupancy");
   endtask

   task automatic test_wrap();
      bit done;
      int s0;
      logic [1:0] sz;
      logic [paddr_width_p-1:0] a;
      done = 1'b0;
      s0 = sent;
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               sz = 2'($urandom_range(0, 3));
               a = {8'h80, 32'($urandom())};
               if (sz == 2'd3) a[2:0] = 3'b000;
               push_store(a, {32'($urandom()), 32'($urandom())}, sz);
            end
            done = 1'b1;
         end
         begin
            for (int c = 0; c < 3000 && !done; c++) begin
               lrdy = 1'($urandom_range(0, 1));
               cret = (outstanding > 0) && ($urandom_range(0, 1) == 1);
               tick(1);
            end
            cret = 1'b0;
         end
      join
      drain("wrap");
      checks++; if (sent - s0 != 20) begin errors++; $display("FAIL wrap_count: got %0d required 20", sent - s0); end
   endtask

   task automatic test_reset_mid();
      lrdy = 1'b1;
      for (int i = 0; i < 5; i++) push_store(40'h00_4000_0000 + 40'(i * 64), 64'hB0 + 64'(i), 2'd2);
      tick(2);
      lrdy = 1'b0;
      for (int i = 0; i < 3; i++) push_store(40'h00_4100_0000 + 40'(i * 64), 64'hB8 + 64'(i), 2'd2);
      checks++; if (outstanding != 5 || exp_q.size() != 3) begin errors++; $display("FAIL mid_setup: got outstanding=%0d pending=%0d required 5 and 3", outstanding, exp_q.size()); end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      exp_q.delete();
      outstanding = 0;
      lrdy = 1'b1;
      #1;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b required 1", empty); end
      checks++; if (req_v !== 1'b0) begin errors++; $display("FAIL mid_req_v: got %b required 0", req_v); end
      checks++; if (rdy_o !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b required 1", rdy_o); end
      checks++; if (cfull !== 1'b0) begin errors++; $display("FAIL mid_credits_full: got %b required 0", cfull); end
      tick(3);
      v = 1'b1; addr = 40'h00_8000_0100; data = 64'h1234_5678_9ABC_DEF0; size = 2'd3;
      if (rdy_o === 1'b1) exp_q.push_back('{addr: addr, data: data, size: size});
      #1;
      checks++; if (req_v !== byp_lp) begin errors++; $display("FAIL post_accept_cycle: got req_v=%b required %b", req_v, byp_lp); end
      tick(1);
      v = 1'b0;
      checks++; if (req_v !== !byp_lp) begin errors++; $display("FAIL post_next_cycle: got req_v=%b required %b", req_v, !byp_lp); end
      drain("post_reset");
   endtask

   initial begin
      rst = 1'b1; v = 1'b0; lrdy = 1'b0; cret = 1'b0;
      addr = '0; data = '0; size = '0;
      tick(3);
      rst = 1'b0;
      test_reset();
      test_single();
      test_fill();
      test_credit_stall();
      test_same_cycle();
      test_wrap();
      test_reset_mid();
      tick(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion by 2 ms, required finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/bp_be_dcache_uc_store_buffer.md
Name: bp_be_dcache_uc_store_buffer

Overview:
- Buffers uncached stores from the dcache pipeline before they are issued as e_lce_req_type_uc_wr requests on the LCE request channel.
- Sits between the dcache and the LCE request handler's output port, sharing the LCE request network.
- Decouples the dcache from network backpressure and bounds outstanding uncached writes with a credit counter.
- Produces a fence-quality empty indication.

Parameters:
- bp_params_p, e_bp_inv_cfg: processor config; supplies paddr_width_p, dword_width_p, lce_id_width_p, cce_id_width_p and the LCE/CCE interface widths.
- els_p, 4: buffer depth in entries; power of two, >= 2.
- credits_p, 8: maximum uncached stores outstanding in the memory system.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- lce_id_i  in  lce_id_width_p  source LCE id.
- uc_store_v_i  in  1  uncached store valid.
- uc_store_addr_i  in  paddr_width_p  store physical address.
- uc_store_data_i  in  dword_width_p  store data, LSB-aligned.
- uc_store_size_i  in  2  log2 of the byte count: 0=1B, 1=2B, 2=4B, 3=8B.
- uc_store_ready_o  out  1  buffer can accept a store.
- lce_req_o  out  lce_cce_req_width_lp  packed bp_lce_cce_req_s.
- lce_req_v_o  out  1  request valid.
- lce_req_ready_i  in  1  network ready.
- credit_return_i  in  1  one uncached-write completion returned.
- credits_full_o  out  1  outstanding count equals credits_p.
- empty_o  out  1  buffer empty and zero outstanding credits.

Behaviour:
- Reset values:
  - uc_store_ready_o=1, lce_req_v_o=0, credits_full_o=0, empty_o=1.
  - Read/write pointers=0, credit count=0.
  - Reset mid-operation drops all buffered entries and all outstanding credits.
- Storage: circular buffer of els_p entries {addr, data, size}.
  - Pointers carry one extra wrap bit.
  - full = pointer indices equal and wrap bits differ; empty = pointers fully equal.
- Enqueue handshake: uc_store_ready_o = ~full, registered state only.
  - Accept when uc_store_v_i & uc_store_ready_o.
  - Store is written at the write pointer and the pointer increments, wrapping els_p-1 -> 0 and toggling the wrap bit.
- Dequeue handshake: ready-then-valid, consistent with the LCE request channel.
  - lce_req_v_o = ~empty & lce_req_ready_i & ~credits_full_o.
  - Asserting lce_req_v_o is the send; the read pointer increments the same cycle.
- lce_req_o fields, driven from the head entry:
  - msg_type = e_lce_req_type_uc_wr.
  - addr = head addr; size = bp_mem_msg_size_e'(head size); data = head data.
  - src_id = lce_id_i; dst_id from bp_me_addr_to_cce_id(head addr).
  - All other fields 0.
  - Output is don't-care when lce_req_v_o=0, but is driven from the head entry (no X).
- Latency: without bypass, minimum 1 cycle from accept to lce_req_v_o.
- Simultaneous enqueue and dequeue in a non-full, non-empty buffer: both occur and occupancy is unchanged.
  - At full, enqueue is blocked even if a dequeue occurs that cycle.
- Credit counter, width clog2(credits_p+1):
  - +1 on send, -1 on credit_return_i; both in the same cycle leaves it unchanged.
  - credit_return_i at count 0: count holds 0 and a simulation assertion fires.
  - credits_full_o = (count == credits_p), registered.
- empty_o = buffer empty & count==0; combinational from registers.
- Ordering: strict FIFO; no merging or reordering.
- Assertions (translate_off):
  - No credit underflow.
  - No enqueue while full.
  - uc_store_size_i == 3 requires addr[2:0]==0.

Optional Feature:
- Macro: BP_DCACHE_UC_STORE_BYPASS_EN.
- Defined: when the buffer is empty, credits are available and lce_req_ready_i=1, an accepted store is driven directly onto lce_req_o/lce_req_v_o in the same cycle.
  - The store is not written into the buffer and the pointers do not move.
  - The credit counter still increments.
  - Zero-cycle latency.
- Undefined: every store passes through the buffer, with 1-cycle minimum latency.

Decomposition:
- Shared package bp_be_dcache_pkg:
  - bp_be_dcache_uc_store_entry_s {addr, data, size}.
  - Size encoding constants.
- Reuse bp_lce_cce_req_s and bp_me_addr_to_cce_id from the common LCE/CCE interface.
- One natural sub-module: bp_be_dcache_uc_credit_counter.
  - Up/down saturating-at-assert counter exposing count, full and zero.

Test Plan:
- Single store, addr=0x8000_0010, data=0xDEAD_BEEF, size=2, ready=1 -> lce_req_v_o 1 cycle later with uc_wr, size=4B, matching addr/data; credits 0->1; empty_o=0 until credit_return_i, then empty_o=1.
- Push 4 stores with lce_req_ready_i=0 (els_p=4) -> uc_store_ready_o=0 after the 4th; raise ready -> 4 requests in FIFO order on consecutive cycles, ready_o re-asserts the cycle after the first send.
- Credit stall with credits_p=8 and no returns: push 10 stores -> exactly 8 sent, credits_full_o=1, 2 held; pulse credit_return_i once -> exactly one more sent.
- Same cycle send + credit_return_i at count 3 -> count stays 3; simultaneous enqueue+dequeue at occupancy 2 -> occupancy stays 2.
- Pointer wrap: stream 20 stores with random ready -> output sequence equals input sequence, no loss or duplication.
- Reset asserted with 3 entries buffered and 5 credits outstanding -> next cycle empty_o=1, lce_req_v_o=0, uc_store_ready_o=1; with bypass macro defined, a store into an empty buffer appears on lce_req_o in the accept cycle.
